// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared defaults, FSM type and buffer depth for the 1rw1r SRAM controller
package sram_ctrl_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int RSP_DEPTH          = 2;

  typedef enum logic {INIT, RUN} ctrl_state_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - 2-entry valid/ready read-response buffer with occupancy count
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);
  localparam int         PW   = $clog2(RSP_DEPTH);
  localparam logic [1:0] FULL = 2'(RSP_DEPTH);

  logic [WIDTH-1:0] mem [RSP_DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // A pop frees a slot in the same edge, so a full buffer still takes a push.
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & ((count != FULL) | pop);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rptr];
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= in_data;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/sram_1rw1r_ctrl.sv
// rtl/sram_1rw1r_ctrl.sv - request/response controller for the 64x8 1rw1r OpenRAM macro
module sram_1rw1r_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_wdata,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
  output logic                  init_done,
  output logic                  sram_clk0,
  output logic                  sram_clk1,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);
  ctrl_state_t           state;
  ctrl_state_t           state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [1:0]            inflight0;
  logic [1:0]            inflight1;
  logic [1:0]            occ0;
  logic [1:0]            occ1;
  logic [2:0]            out0;
  logic [2:0]            out1;
  logic                  credit0;
  logic                  credit1;
  logic                  hazard;
  logic                  clearing;
  logic                  acc0;
  logic                  acc1;

  assign sram_clk0 = clk;
  assign sram_clk1 = clk;

  // Outstanding reads: pipeline stages plus buffered responses must fit the buffer.
  assign out0    = 3'(inflight0[0]) + 3'(inflight0[1]) + 3'(occ0);
  assign out1    = 3'(inflight1[0]) + 3'(inflight1[1]) + 3'(occ1);
  assign credit0 = (out0 < 3'(RSP_DEPTH));
  assign credit1 = (out1 < 3'(RSP_DEPTH));
  assign acc0    = p0_req_valid & p0_req_ready;
  assign acc1    = p1_req_valid & p1_req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT: if (!CLEAR_ON_RESET || (&clr_cnt)) state_next = RUN;
      RUN:  state_next = RUN;
    endcase
  end

  // Port 1 yields to a same-address port-0 write so the read sees the new data.
  always_comb begin
    init_done    = (state == RUN);
    clearing     = (state == INIT) && CLEAR_ON_RESET;
    hazard       = p0_req_valid && p0_req_we && p1_req_valid && (p0_req_addr == p1_req_addr);
    p0_req_ready = (state == RUN) && credit0;
    p1_req_ready = (state == RUN) && credit1 && !hazard;
  end

  always_ff @(posedge clk) begin
    if (rst) clr_cnt <= '0;
    else if (clearing) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
    end else begin
      sram_csb0 <= ~(clearing | acc0);
      if (clearing) begin
        sram_web0  <= 1'b0;
        sram_addr0 <= clr_cnt;
        sram_din0  <= '0;
      end else if (acc0) begin
        sram_web0  <= ~p0_req_we;
        sram_addr0 <= p0_req_addr;
        sram_din0  <= p0_req_wdata;
      end
      sram_csb1 <= ~acc1;
      if (acc1) sram_addr1 <= p1_req_addr;
    end
  end

  // Stage 1 = macro samples the read, stage 2 = dout is captured into the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight0 <= '0;
      inflight1 <= '0;
    end else begin
      inflight0 <= {inflight0[0], acc0 & ~p0_req_we};
      inflight1 <= {inflight1[0], acc1};
    end
  end

  sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_rsp0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight0[1]),
    .in_data   (sram_dout0),
    .out_valid (p0_rsp_valid),
    .out_ready (p0_rsp_ready),
    .out_data  (p0_rsp_rdata),
    .occupancy (occ0)
  );

  sram_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_rsp1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight1[1]),
    .in_data   (sram_dout1),
    .out_valid (p1_rsp_valid),
    .out_ready (p1_rsp_ready),
    .out_data  (p1_rsp_rdata),
    .occupancy (occ1)
  );
endmodule
